// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexes an 8-bit count onto a 4-digit common-anode
// seven-segment display. Each digit owns one slot of REFRESH_DIV clocks.
// The count and terminal-count flag are latched once per scan frame.
// Optional macro SEG_BCD_EN: decimal display through a double-dabble FSM.
// Without it, the display shows two hex digits and busy stays 0.
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk_100M,
  input  logic       reset,
  input  logic [7:0] value,
  input  logic       tc,
  input  logic       blank,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       busy
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [CW-1:0] rcnt;
  logic [1:0]    dig;
  logic          first;
  logic [7:0]    snap;
  logic          snap_tc;
  logic          slot_end;
  logic          snap_en;

  // Display registers: digit values and lit flags for slots 1 and 2.
  // Slot 0 is always lit, and slot 3 is never lit.
  logic [3:0]    d0, d1, d2;
  logic          lit1, lit2;

  assign slot_end = (rcnt == CW'(REFRESH_DIV - 1));
  // Take a new frame on the 3->0 wrap, and once right after reset so that
  // the first frame shows live data.
  assign snap_en  = first || (slot_end && (dig == 2'd3));

  // Refresh divider and digit index
  always_ff @(posedge clk_100M or posedge reset) begin
    if (reset) begin
      rcnt <= '0;
      dig  <= 2'd0;
    end else if (slot_end) begin
      rcnt <= '0;
      dig  <= dig + 2'd1;
    end else begin
      rcnt <= rcnt + 1'b1;
    end
  end

  // First-cycle-after-reset marker
  always_ff @(posedge clk_100M or posedge reset) begin
    if (reset) first <= 1'b1;
    else       first <= 1'b0;
  end

  // Frame snapshot of the count and terminal-count flag
  always_ff @(posedge clk_100M or posedge reset) begin
    if (reset) begin
      snap    <= 8'h00;
      snap_tc <= 1'b0;
    end else if (snap_en) begin
      snap    <= value;
      snap_tc <= tc;
    end
  end

`ifdef SEG_BCD_EN
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;

  logic [1:0]  state;
  logic [11:0] bcd;
  logic [11:0] bcd_adj;
  logic [2:0]  bit_cnt;

  // Double-dabble add-3 step: any BCD nibble of 5 or more gets +3 before the shift.
  always_comb begin
    bcd_adj = bcd;
    if (bcd[3:0]  >= 4'd5) bcd_adj[3:0]  = bcd[3:0]  + 4'd3;
    if (bcd[7:4]  >= 4'd5) bcd_adj[7:4]  = bcd[7:4]  + 4'd3;
    if (bcd[11:8] >= 4'd5) bcd_adj[11:8] = bcd[11:8] + 4'd3;
  end

  // Conversion FSM. Snapshot bits shift in MSB first. The display registers
  // change only in LOAD, so no partial value is ever shown.
  always_ff @(posedge clk_100M or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      bcd     <= 12'h000;
      bit_cnt <= 3'd0;
      d0      <= 4'h0;
      d1      <= 4'h0;
      d2      <= 4'h0;
      lit1    <= 1'b0;
      lit2    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (snap_en) begin
          state   <= S_SHIFT;
          bcd     <= 12'h000;
          bit_cnt <= 3'd0;
        end
        S_SHIFT: begin
          bcd     <= {bcd_adj[10:0], snap[3'd7 - bit_cnt]};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state <= S_LOAD;
        end
        S_LOAD: begin
          d0    <= bcd[3:0];
          d1    <= bcd[7:4];
          d2    <= bcd[11:8];
          lit2  <= (bcd[11:8] != 4'h0);
          lit1  <= (bcd[11:4] != 8'h00);
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);
`else
  // Hex mode: the snapshot register is the display register.
  assign d0   = snap[3:0];
  assign d1   = snap[7:4];
  assign d2   = 4'h0;
  assign lit1 = 1'b1;
  assign lit2 = 1'b0;
  assign busy = 1'b0;
`endif

  function automatic logic [6:0] glyph(input logic [3:0] h);
    case (h)
      4'h0: glyph = 7'b1000000;  4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;  4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;  4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;  4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;  4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;  4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;  4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;  default: glyph = 7'b0001110;
    endcase
  endfunction

  logic [3:0] cur;
  logic       cur_lit;

  // Select the digit for the current slot
  always_comb begin
    cur     = d0;
    cur_lit = 1'b1;
    case (dig)
      2'd1:    begin cur = d1; cur_lit = lit1; end
      2'd2:    begin cur = d2; cur_lit = lit2; end
      2'd3:    begin cur = d0; cur_lit = 1'b0; end
      default: begin cur = d0; cur_lit = 1'b1; end
    endcase
  end

  // Registered pin drive. It lags the digit index by one cycle, and it holds
  // the off state during the snapshot cycle right after reset.
  always_ff @(posedge clk_100M or posedge reset) begin
    if (reset) begin
      an  <= 4'b1111;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else if (!first) begin
      an  <= (cur_lit && !blank) ? ~(4'b0001 << dig) : 4'b1111;
      seg <= (cur_lit && !blank) ? glyph(cur) : 7'h7F;
      dp  <= !((dig == 2'd0) && snap_tc);
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver with REFRESH_DIV=16.
// For each frame, the stimulus side pushes the four expected slot images into
// a queue. The monitor pops one image late in each slot and compares it.
module tb_seg7_scan_driver;
  localparam int DIV   = 16;
  localparam int FRAME = 4 * DIV;

  logic       clk_100M = 1'b0;
  logic       reset;
  logic [7:0] value;
  logic       tc, blank;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp, busy;

  seg7_scan_driver #(.REFRESH_DIV(DIV)) dut (
    .clk_100M(clk_100M), .reset(reset), .value(value), .tc(tc), .blank(blank),
    .an(an), .seg(seg), .dp(dp), .busy(busy)
  );

  initial forever #5 clk_100M = ~clk_100M;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } slot_t;

  slot_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    n;          // clock edges since reset release
  int    fidx = 0;   // stimulus frame index

  logic [6:0] glyph_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Directed frames first (value, tc, blank), then random frames.
  localparam int NDIR = 8;
  logic [7:0] dir_v [NDIR] = '{8'd255, 8'd7, 8'h01, 8'h02, 8'd0, 8'd9, 8'd100, 8'd10};
  logic       dir_t [NDIR] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic       dir_b [NDIR] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  always @(posedge clk_100M or posedge reset)
    if (reset) n <= 0;
    else       n <= n + 1;

  // Reference model: the expected image for slot k of a frame showing v.
  function automatic slot_t model_slot(int k, int v, bit t, bit b);
    int dv[4];
    bit lit[4];
    slot_t s;
`ifdef SEG_BCD_EN
    dv[0] = v % 10; dv[1] = (v / 10) % 10; dv[2] = v / 100; dv[3] = 0;
    lit[0] = 1; lit[1] = (v >= 10); lit[2] = (v >= 100); lit[3] = 0;
`else
    dv[0] = v % 16; dv[1] = v / 16; dv[2] = 0; dv[3] = 0;
    lit[0] = 1; lit[1] = 1; lit[2] = 0; lit[3] = 0;
`endif
    if (lit[k] && !b) begin
      s.an  = 4'b1111;
      s.an[k] = 1'b0;
      s.seg = glyph_tab[dv[k]];
    end else begin
      s.an  = 4'b1111;
      s.seg = 7'h7F;
    end
    s.dp = !(k == 0 && t);
    return s;
  endfunction

  task automatic push_frame(input logic [7:0] v, input logic t, input logic b);
    for (int k = 0; k < 4; k++) exp_q.push_back(model_slot(k, v, t, b));
  endtask

  task automatic check_rst(input string nm);
    n_cmp++;
    if ({an, seg, dp, busy} !== {4'b1111, 7'h7F, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL %s: got an=%b seg=%b dp=%b busy=%b, want an=1111 seg=1111111 dp=1 busy=0",
               nm, an, seg, dp, busy);
    end
  endtask

  task automatic wait_lit(input string nm);
    bit found = 0;
    for (int i = 0; i < 17 && !found; i++) begin
      @(negedge clk_100M);
      if (an === 4'b1110) found = 1;
    end
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL %s: digit 0 not lit within 17 cycles, an=%b want 1110", nm, an);
    end
  endtask

  // Stimulus up to edge count 'target' (bounded). A decoy value arrives in
  // slot 1, and it must never appear. The real next-frame inputs are set just
  // before the 3->0 wrap.
  task automatic run_until(input int target);
    logic [7:0] v;
    logic       t, b;
    for (int i = 0; i < target + 2 && n < target; i++) begin
      @(negedge clk_100M);
      if (n % FRAME == 24) begin
        value = 8'($urandom);
        tc    = 1'($urandom);
      end
      if (n % FRAME == FRAME - 1) begin
        if (fidx < NDIR) begin
          v = dir_v[fidx]; t = dir_t[fidx]; b = dir_b[fidx];
        end else begin
          v = 8'($urandom); t = 1'($urandom); b = ($urandom_range(0, 3) == 0);
        end
        fidx++;
        value = v; tc = t; blank = b;
        push_frame(v, t, b);
      end
    end
  endtask

  // Monitor: one comparison per slot, plus busy checks inside each frame.
  initial forever begin
    slot_t e;
    int    k;
    @(negedge clk_100M);
    if (!reset && n > 0) begin
      if (n % DIV == 14) begin
        k = ((n - 1) / DIV) % 4;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL slot%0d at n=%0d: no expected entry queued", k, n);
        end else begin
          e = exp_q.pop_front();
          if ({an, seg, dp} !== e) begin
            n_err++;
            $display("FAIL slot%0d at n=%0d: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                     k, n, an, seg, dp, e.an, e.seg, e.dp);
          end
        end
      end
      if (n % FRAME == 5 || n % FRAME == 12 || n % DIV == 14) begin
`ifdef SEG_BCD_EN
        k = (n % FRAME == 5) ? 1 : 0;
`else
        k = 0;
`endif
        n_cmp++;
        if (busy !== k[0]) begin
          n_err++;
          $display("FAIL busy at n=%0d: got %b want %0d", n, busy, k);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; value = 8'hA5; tc = 1'b0; blank = 1'b0;
    repeat (3) @(negedge clk_100M);
    check_rst("reset_initial");
    push_frame(8'hA5, 1'b0, 1'b0);
    reset = 1'b0;
    wait_lit("lit_after_reset1");
    run_until(20 * FRAME + 4);

    // Reset asserted mid-frame. In decimal mode this is also mid-conversion.
    #2 reset = 1'b1;
    #1 check_rst("reset_mid_scan");
    exp_q.delete();
    value = 8'd200; tc = 1'b1; blank = 1'b0;
    push_frame(8'd200, 1'b1, 1'b0);
    repeat (3) @(negedge clk_100M);
    reset = 1'b0;
    wait_lit("lit_after_reset2");
    run_until(12 * FRAME);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
